tick_burst_ctrl: RTL

Programmable controller that sequences the SDR_SYNC periodic tick. It latches a period and a pulse count, optionally arms on an external sync edge, and emits single-cycle ticks on `Clock_O` in either burst or continuous mode. It reports busy, done and progress status to the register interface. It replaces free-running fixed-parameter tick generation wherever software must start, stop or phase-align the tick.

---
 rtl/tick_burst_ctrl.sv | 89 ++++++++
 1 files changed

// File: rtl/tick_burst_ctrl.sv
// tick_burst_ctrl: programmable burst/continuous tick sequencer with optional sync-edge arming
module tick_burst_ctrl #(
    parameter int PERIOD_BITS = 32,
    parameter int CNT_BITS    = 16
) (
    input  logic                   Clock_I,
    input  logic                   Reset_I,
    input  logic [PERIOD_BITS-1:0] Period_I,
    input  logic [CNT_BITS-1:0]    Pulses_I,
    input  logic                   Start_I,
    input  logic                   Stop_I,
    input  logic                   SyncEn_I,
    input  logic                   Sync_I,
    output logic                   Clock_O,
    output logic                   Busy_O,
    output logic                   Done_O,
    output logic [CNT_BITS-1:0]    PulseCnt_O
);
    typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;
    state_t state, state_nxt;
    logic [PERIOD_BITS-1:0] per_q, per_nxt, cnt_q, cnt_nxt;
    logic [CNT_BITS-1:0] num_q, num_nxt, pulse_nxt, pulse_inc;
    logic sync_q, tick_nxt, done_nxt;
    assign pulse_inc = PulseCnt_O + CNT_BITS'(1);
    always_comb begin
        state_nxt = state;
        per_nxt = per_q;
        num_nxt = num_q;
        cnt_nxt = cnt_q;
        pulse_nxt = PulseCnt_O;
        tick_nxt = 1'b0;
        done_nxt = 1'b0;
        case (state)
            IDLE: if (Start_I && !Stop_I) begin
                per_nxt = Period_I;
                num_nxt = Pulses_I;
                cnt_nxt = '0;
                pulse_nxt = '0;
                state_nxt = SyncEn_I ? ARMED : RUN;
            end
            ARMED: if (Stop_I) begin
                state_nxt = IDLE;
                done_nxt = 1'b1;
            end else if (Sync_I && !sync_q) begin
                state_nxt = RUN;
                cnt_nxt = '0;
            end
            RUN: if (Stop_I) begin
                state_nxt = IDLE;
                done_nxt = 1'b1;
            end else if (cnt_q == per_q) begin
                cnt_nxt = '0;
                tick_nxt = 1'b1;
                pulse_nxt = pulse_inc;
                // Last tick of a finite burst retires the block on the same edge
                if (num_q != '0 && pulse_inc == num_q) begin
                    state_nxt = IDLE;
                    done_nxt = 1'b1;
                end
            end else begin
                cnt_nxt = cnt_q + PERIOD_BITS'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge Clock_I or posedge Reset_I) begin
        if (Reset_I) begin
            state <= IDLE;
            per_q <= '0;
            num_q <= '0;
            cnt_q <= '0;
            sync_q <= 1'b0;
            Clock_O <= 1'b0;
            Busy_O <= 1'b0;
            Done_O <= 1'b0;
            PulseCnt_O <= '0;
        end else begin
            state <= state_nxt;
            per_q <= per_nxt;
            num_q <= num_nxt;
            cnt_q <= cnt_nxt;
            sync_q <= Sync_I;
            Clock_O <= tick_nxt;
            Busy_O <= state_nxt != IDLE;
            Done_O <= done_nxt;
            PulseCnt_O <= pulse_nxt;
        end
    end
endmodule
